// File: rtl/cont_anel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cont_anel_ctrl_pkg
// Purpose : Shared definitions for the ring-counter sequencer: FSM state
//           encoding, default timing values and a counter-width helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package cont_anel_ctrl_pkg;

  // Encoding is visible on LEDG through state_o, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam int c_DIV_DEFAULT     = 50_000_000;  // 1 Hz run tick from CLOCK_50
  localparam int c_DEB_CYC_DEFAULT = 1_000_000;   // 20 ms key stability window

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cont_anel_ctrl_deb_tecla.sv
`default_nettype none
// ============================================================================
// Module  : deb_tecla
// Purpose : Key conditioner: 2-FF synchronizer, debouncer and a one-cycle
//           pulse on each debounced press (1 -> 0) of an active-low key.
// Ports   : clk_i    in   clock
//           rst_i    in   asynchronous active-high reset
//           key_n_i  in   raw active-low key, bouncy, asynchronous
//           press_o  out  registered one-cycle pulse per accepted press
// Rev     : 1.0  initial release
// ============================================================================
module deb_tecla
  import cont_anel_ctrl_pkg::*;
#(
  parameter int DEB_CYC = c_DEB_CYC_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = cnt_width(DEB_CYC);

  logic [1:0]    sync_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Synchronizer resets to "released" so a reset never fakes a press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_n_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  // The counter measures how long the synced key has disagreed with the
  // accepted value; any agreement restarts the window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) begin
        stable_d = sync_q[1];
        press_d  = ~sync_q[1];   // only the press direction produces a pulse
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/cont_anel_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cont_anel_ctrl
// Purpose : Sequencer for the DE2 4-bit ring counter. Generates single-cycle
//           shift/load enables from CLOCK_50: free-run on a divided tick,
//           single-step from a debounced key, or parallel load.
// Ports   : CLOCK_50    in   sole clock, rising edge
//           clr         in   asynchronous active-high reset
//           run_req     in   level, 1 = free-run, 0 = pause
//           load_req    in   rising edge requests a pattern load
//           step_n      in   raw active-low key, one shift per press in PAUSE
//           pat_in      in   [W] pattern to load
//           ring_ck_en  out  one-cycle enable to the ring counter
//           ring_sel    out  1 = load ring_d, 0 = shift
//           ring_d      out  [W] registered load pattern
//           state_o     out  [2] current FSM state
// Rev     : 1.0  initial release
// ============================================================================
module cont_anel_ctrl
  import cont_anel_ctrl_pkg::*;
#(
  parameter int W       = 4,
  parameter int DIV     = c_DIV_DEFAULT,
  parameter int DEB_CYC = c_DEB_CYC_DEFAULT
) (
  input  logic         CLOCK_50,
  input  logic         clr,
  input  logic         run_req,
  input  logic         load_req,
  input  logic         step_n,
  input  logic [W-1:0] pat_in,
  output logic         ring_ck_en,
  output logic         ring_sel,
  output logic [W-1:0] ring_d,
  output logic [1:0]   state_o
);

  localparam int CNT_W = cnt_width(DIV);

  logic [1:0]       run_sync_q;
  logic [1:0]       load_sync_q;
  logic             load_prev_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             en_q, en_d;
  logic             sel_q, sel_d;
  logic [W-1:0]     pat_q, pat_d;

  logic w_load_edge;
  logic w_run;
  logic w_tick;
  logic w_step_p;

  deb_tecla #(
    .DEB_CYC (DEB_CYC)
  ) u_deb_step (
    .clk_i   (CLOCK_50),
    .rst_i   (clr),
    .key_n_i (step_n),
    .press_o (w_step_p)
  );

  assign w_load_edge = load_sync_q[1] & ~load_prev_q;
  assign w_run       = run_sync_q[1];
  assign w_tick      = (state_q == ST_RUN) && (tick_cnt_q == CNT_W'(DIV - 1));

  // State register plus synchronizers, tick counter and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge clr) begin
    if (clr) begin
      run_sync_q  <= 2'b00;
      load_sync_q <= 2'b00;
      load_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      en_q        <= 1'b0;
      sel_q       <= 1'b0;
      pat_q       <= '0;
    end else begin
      run_sync_q  <= {run_sync_q[0], run_req};
      load_sync_q <= {load_sync_q[0], load_req};
      load_prev_q <= load_sync_q[1];
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      en_q        <= en_d;
      sel_q       <= sel_d;
      pat_q       <= pat_d;
    end
  end

  // The counter only advances in RUN and sits at zero everywhere else, so
  // every entry to RUN starts a full DIV-cycle period.
  assign tick_cnt_d = (state_q != ST_RUN || w_tick) ? '0 : tick_cnt_q + CNT_W'(1);

  // Next state: load edge beats a run_req change, which beats tick/step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_load_edge) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = w_run ? ST_RUN : ST_PAUSE;
      end
      ST_RUN: begin
        if (w_load_edge)  state_d = ST_LOAD;
        else if (!w_run)  state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (w_load_edge)  state_d = ST_LOAD;
        else if (w_run)   state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decided from the transition and registered, so the enable
  // appears in the same cycle the FSM enters LOAD. A tick or step only fires
  // when the FSM stays put; a competing transition drops it.
  always_comb begin
    en_d  = 1'b0;
    sel_d = 1'b0;
    pat_d = pat_q;
    if (state_d == ST_LOAD) begin
      en_d  = 1'b1;
      sel_d = 1'b1;
      // An all-zero ring would never shift anything visible; seed one bit.
      pat_d = (pat_in == '0) ? W'(1) : pat_in;
    end else if (state_d == ST_RUN && w_tick) begin
      en_d = 1'b1;
    end else if (state_q == ST_PAUSE && state_d == ST_PAUSE && w_step_p) begin
      en_d = 1'b1;
    end
  end

  assign ring_ck_en = en_q;
  assign ring_sel   = sel_q;
  assign ring_d     = pat_q;
  assign state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cont_anel_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cont_anel_ctrl
// Purpose : Self-checking bench for cont_anel_ctrl with DIV=4, DEB_CYC=3, W=4.
//           Expected timing is computed from the sequencing rules (edge counts,
//           tick periods, run lengths of the key input).
// Rev     : 1.0  initial release
// ============================================================================
module tb_cont_anel_ctrl;

  localparam int W   = 4;
  localparam int DIV = 4;
  localparam int DEB = 3;

  logic         clk      = 1'b0;
  logic         clr      = 1'b1;
  logic         run_req  = 1'b0;
  logic         load_req = 1'b0;
  logic         step_n   = 1'b1;
  logic [W-1:0] pat_in   = '0;
  logic         en;
  logic         sel;
  logic [W-1:0] rd;
  logic [1:0]   st;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cont_anel_ctrl #(
    .W       (W),
    .DIV     (DIV),
    .DEB_CYC (DEB)
  ) dut (
    .CLOCK_50   (clk),
    .clr        (clr),
    .run_req    (run_req),
    .load_req   (load_req),
    .step_n     (step_n),
    .pat_in     (pat_in),
    .ring_ck_en (en),
    .ring_sel   (sel),
    .ring_d     (rd),
    .state_o    (st)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr      = 1'b1;
    run_req  = 1'b0;
    load_req = 1'b0;
    step_n   = 1'b1;
    pat_in   = '0;
    repeat (2) cyc();
    clr = 1'b0;
    repeat (3) cyc();
  endtask

  function automatic logic [W-1:0] load_val(input logic [W-1:0] p);
    return (p == '0) ? W'(1) : p;
  endfunction

  // Number of accepted presses: a run of samples at the opposite level lasting
  // at least DEB cycles flips the accepted level; count the flips to 0.
  function automatic int model_presses(input bit q[$]);
    int n;
    int k;
    int len;
    bit stable;
    bit v;
    n = 0; k = 0; stable = 1'b1;
    while (k < q.size()) begin
      v = q[k];
      len = 0;
      while (k < q.size() && q[k] == v) begin
        len++;
        k++;
      end
      if (v != stable && len >= DEB) begin
        stable = v;
        if (!v) n++;
      end
    end
    return n;
  endfunction

  // Plays a key sequence one sample per cycle plus an idle tail and reports
  // the pulses seen and how many of them were malformed.
  task automatic drive_key(input bit q[$], output int n_en, output int bad);
    logic prev_en;
    prev_en = 1'b0;
    n_en = 0;
    bad  = 0;
    for (int i = 0; i < q.size() + 10; i++) begin
      step_n = (i < q.size()) ? q[i] : 1'b1;
      cyc();
      if (en) begin
        n_en++;
        if (sel || prev_en) bad++;
      end
      prev_en = en;
    end
    step_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [W-1:0] a;
    int hold;
    cyc();
    n_tests++;
    if ({en, sel, rd, st} !== 8'h00) begin
      n_fail++; $display("FAIL reset_state: got %b want 00000000", {en, sel, rd, st});
    end
    a = W'($urandom);
    run_req = 1'b1; load_req = 1'b1; pat_in = a;
    for (int i = 0; i < 4; i++) begin
      step_n = i[0];
      cyc();
    end
    step_n = 1'b1;
    n_tests++;
    if ({en, sel, rd, st} !== 8'h00) begin
      n_fail++; $display("FAIL reset_held: got %b want 00000000", {en, sel, rd, st});
    end
    clr = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      n_tests++;
      if (i < 3) begin
        if ({en, st} !== 3'b000) begin
          n_fail++; $display("FAIL reset_release_quiet: edge %0d got %b want 000", i, {en, st});
        end
      end else if ({en, sel, rd, st} !== {1'b1, 1'b1, load_val(a), 2'd1}) begin
        n_fail++; $display("FAIL reset_release_load: got %b want %b", {en, sel, rd, st},
                           {1'b1, 1'b1, load_val(a), 2'd1});
      end
    end
    hold = $urandom_range(2, 9);
    repeat (hold) cyc();
    #2;
    clr = 1'b1;
    #1;
    n_tests++;
    if ({en, sel, rd, st} !== 8'h00) begin
      n_fail++; $display("FAIL reset_async: got %b want 00000000", {en, sel, rd, st});
    end
    cyc();
    n_tests++;
    if ({en, sel, rd, st} !== 8'h00) begin
      n_fail++; $display("FAIL reset_next: got %b want 00000000", {en, sel, rd, st});
    end
    clr = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      cyc();
      n_tests++;
      if ({en, st} !== 3'b000) begin
        n_fail++; $display("FAIL reset_abort_quiet: edge %0d got %b want 000", i, {en, st});
      end
    end
  endtask

  // Load requested with load_req low beforehand; enable must land on the 3rd
  // edge after the pin rises, then the FSM follows run_req.
  task automatic test_load(input logic [W-1:0] pat, input logic run, input string tag);
    pat_in   = pat;
    load_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      n_tests++;
      if (i < 3) begin
        if (en !== 1'b0) begin
          n_fail++; $display("FAIL %s_early: edge %0d got en=%b want 0", tag, i, en);
        end
      end else if (i == 3) begin
        if ({en, sel, rd, st} !== {1'b1, 1'b1, load_val(pat), 2'd1}) begin
          n_fail++; $display("FAIL %s_pulse: got %b want %b", tag, {en, sel, rd, st},
                             {1'b1, 1'b1, load_val(pat), 2'd1});
        end
      end else if ({en, st} !== {1'b0, (run ? 2'd2 : 2'd3)}) begin
        n_fail++; $display("FAIL %s_after: got %b want %b", tag, {en, st},
                           {1'b0, (run ? 2'd2 : 2'd3)});
      end
    end
    load_req = 1'b0;
    repeat (3) cyc();
  endtask

  // From PAUSE: run_req rises, RUN is entered on the 3rd edge and shifts come
  // every DIV cycles starting DIV cycles later, until run_req drops.
  task automatic test_run();
    int   c;
    int   npulse;
    int   nexp;
    logic e_exp;
    c = $urandom_range(51, 60);
    npulse = 0;
    nexp = (c + 2 - (3 + DIV)) / DIV + 1;
    run_req = 1'b1;
    for (int i = 1; i <= c + 12; i++) begin
      cyc();
      e_exp = (i >= 3 + DIV) && ((i - 3 - DIV) % DIV == 0) && (i <= c + 2);
      if (en) npulse++;
      n_tests++;
      if ({en, en & sel} !== {e_exp, 1'b0}) begin
        n_fail++; $display("FAIL run_pulse: edge %0d got en=%b sel=%b want en=%b sel=0", i, en, sel, e_exp);
      end
      if (i == 3 || i == c + 3) begin
        n_tests++;
        if (st !== ((i == 3) ? 2'd2 : 2'd3)) begin
          n_fail++; $display("FAIL run_state: edge %0d got %0d want %0d", i, st, (i == 3) ? 2 : 3);
        end
      end
      if (i == c) run_req = 1'b0;
    end
    n_tests++;
    if (npulse !== nexp) begin
      n_fail++; $display("FAIL run_count: got %0d want %0d", npulse, nexp);
    end
  endtask

  task automatic test_step();
    bit q[$];
    int n_en;
    int bad;
    int nexp;
    // Fixed bounce then long hold, release, second press.
    q = '{1, 0, 1, 0};
    repeat (10) q.push_back(0);
    repeat (6)  q.push_back(1);
    repeat (6)  q.push_back(0);
    repeat (6)  q.push_back(1);
    drive_key(q, n_en, bad);
    n_tests++;
    if (n_en !== 2) begin
      n_fail++; $display("FAIL step_fixed_count: got %0d want 2", n_en);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL step_fixed_shape: got %0d bad pulses want 0", bad);
    end
    for (int r = 0; r < 4; r++) begin
      q.delete();
      repeat ($urandom_range(1, 3)) begin
        repeat ($urandom_range(1, DEB - 1)) q.push_back(0);
        repeat ($urandom_range(1, 2)) q.push_back(1);
      end
      repeat ($urandom_range(1, 10)) q.push_back(0);
      repeat ($urandom_range(0, 2)) begin
        q.push_back(1);
        q.push_back(0);
      end
      repeat (DEB + 2) q.push_back(1);
      nexp = model_presses(q);
      drive_key(q, n_en, bad);
      n_tests++;
      if (n_en !== nexp || bad !== 0) begin
        n_fail++; $display("FAIL step_random_%0d: got %0d pulses (%0d bad) want %0d", r, n_en, bad, nexp);
      end
    end
    n_tests++;
    if (st !== 2'd3) begin
      n_fail++; $display("FAIL step_state: got %0d want 3", st);
    end
  endtask

  task automatic test_step_idle();
    bit q[$];
    int n_en;
    int bad;
    do_reset();
    q.delete();
    repeat (8) q.push_back(0);
    repeat (6) q.push_back(1);
    drive_key(q, n_en, bad);
    n_tests++;
    if ({n_en, st} !== {32'd0, 2'd0}) begin
      n_fail++; $display("FAIL step_idle_ignored: got %0d pulses state %0d want 0 pulses state 0", n_en, st);
    end
  endtask

  task automatic test_zero_pattern();
    do_reset();
    test_load('0, 1'b0, "load_zero");
  endtask

  task automatic test_random_loads();
    for (int r = 0; r < 3; r++) test_load(W'($urandom), 1'b0, "load_rand");
  endtask

  // RUN with a load edge landing on a tick: only the load pulse appears and
  // the tick period restarts from the return to RUN.
  task automatic test_load_vs_tick();
    int           p;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         e_exp;
    logic         s_exp;
    logic [1:0]   st_exp;
    logic [W-1:0] rd_exp;
    do_reset();
    a = W'($urandom);
    b = W'($urandom);
    p = 4 + DIV * int'($urandom_range(2, 4));
    run_req = 1'b1;
    repeat (4) cyc();
    n_tests++;
    if ({en, st} !== 3'b000) begin
      n_fail++; $display("FAIL idle_ignores_run: got %b want 000", {en, st});
    end
    pat_in   = a;
    load_req = 1'b1;
    for (int i = 1; i <= p + 10; i++) begin
      cyc();
      e_exp  = (i == 3) || (i == p) ||
               (i >= 4 + DIV && i < p && ((i - 4) % DIV == 0)) ||
               (i > p && (i - p - 1) >= DIV && ((i - p - 1) % DIV == 0));
      s_exp  = (i == 3) || (i == p);
      st_exp = (i < 3) ? 2'd0 : ((i == 3 || i == p) ? 2'd1 : 2'd2);
      rd_exp = (i < p) ? load_val(a) : load_val(b);
      n_tests++;
      if ({en, en & sel, st} !== {e_exp, s_exp, st_exp}) begin
        n_fail++; $display("FAIL collide_seq: edge %0d got en=%b sel=%b st=%0d want en=%b sel=%b st=%0d",
                           i, en, sel, st, e_exp, s_exp, st_exp);
      end
      if (i >= 3) begin
        n_tests++;
        if (rd !== rd_exp) begin
          n_fail++; $display("FAIL collide_ring_d: edge %0d got %b want %b", i, rd, rd_exp);
        end
      end
      if (i == 5) load_req = 1'b0;
      if (i == p - 3) begin
        load_req = 1'b1;
        pat_in   = b;
      end
    end
    load_req = 1'b0;
    run_req  = 1'b0;
  endtask

  initial begin
    test_reset();
    do_reset();
    test_load(4'b0100, 1'b0, "load_pause");
    test_run();
    test_step();
    test_random_loads();
    test_step_idle();
    test_zero_pattern();
    test_load_vs_tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
